// File: rtl/ifetch_if_id_pkg.sv
// rtl/ifetch_if_id_pkg.sv - shared widths, NOP encoding, fetch FSM states and packet type
package ifetch_if_id_pkg;

  localparam int ADDR_SIZE  = 32;
  localparam int INSTR_SIZE = 32;
  localparam logic [INSTR_SIZE-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_SIZE-1:0]  pc;
    logic [INSTR_SIZE-1:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/ifetch_if_id_if.sv
// rtl/ifetch_if_id_if.sv - instruction cache request/response bus
interface ifetch_if_id_if;
  import ifetch_if_id_pkg::*;

  logic                  ic_req_valid;
  logic [ADDR_SIZE-1:0]  ic_req_addr;
  logic                  ic_req_ready;
  logic                  ic_rsp_valid;
  logic [INSTR_SIZE-1:0] ic_rsp_data;

  // fetch side issues requests and consumes responses
  modport master (
    output ic_req_valid, ic_req_addr,
    input  ic_req_ready, ic_rsp_valid, ic_rsp_data
  );

  // cache side
  modport slave (
    input  ic_req_valid, ic_req_addr,
    output ic_req_ready, ic_rsp_valid, ic_rsp_data
  );

endinterface

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with write enable and flush-to-bubble
module if_id_reg
  import ifetch_if_id_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  write_en,
  input  logic                  ld_valid,
  input  fetch_pkt_t            ld_pkt,
  output logic                  id_valid,
  output logic [ADDR_SIZE-1:0]  id_pc,
  output logic [INSTR_SIZE-1:0] id_instr
);

  localparam fetch_pkt_t BUBBLE = '{pc: '0, instr: NOP_INSTR};

  logic       valid_q;
  fetch_pkt_t pkt_q;

  // flush beats write enable; a write with nothing new loads a bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      pkt_q   <= BUBBLE;
    end else if (flush) begin
      valid_q <= 1'b0;
      pkt_q   <= BUBBLE;
    end else if (write_en) begin
      valid_q <= ld_valid;
      pkt_q   <= ld_valid ? ld_pkt : BUBBLE;
    end
  end

  assign id_valid = valid_q;
  assign id_pc    = pkt_q.pc;
  assign id_instr = pkt_q.instr;

endmodule

// File: rtl/ifetch_if_id.sv
// rtl/ifetch_if_id.sv - icache fetch FSM feeding IF/ID; IFETCH_IF_ID_PERF_EN adds perf counters
module ifetch_if_id
  import ifetch_if_id_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_SIZE-1:0]  pc_in,
  input  logic                  flush,
  input  logic                  if_id_write,
  ifetch_if_id_if.master        ic,
  output logic                  id_valid,
  output logic [ADDR_SIZE-1:0]  id_pc,
  output logic [INSTR_SIZE-1:0] id_instr,
  output logic                  fetch_stall
`ifdef IFETCH_IF_ID_PERF_EN
  ,
  output logic [31:0]           perf_stall_cycles,
  output logic [15:0]           perf_flush_count
`endif
);

  state_t               state_q, state_d;
  logic [ADDR_SIZE-1:0] req_pc_q, req_pc_d;
  logic                 drop_q, drop_d;
  fetch_pkt_t           hold_q, hold_d;
  logic                 req_valid;
  logic                 ld_valid;
  fetch_pkt_t           ld_pkt;

  // state, outstanding request PC, drop flag and hold buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_REQ;
      req_pc_q <= '0;
      drop_q   <= 1'b0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
      drop_q   <= drop_d;
      hold_q   <= hold_d;
    end
  end

  // next state and outputs; reset gates the request so nothing is issued while held
  always_comb begin
    state_d     = state_q;
    req_pc_d    = req_pc_q;
    drop_d      = drop_q;
    hold_d      = hold_q;
    req_valid   = 1'b0;
    fetch_stall = 1'b1;
    ld_valid    = 1'b0;
    ld_pkt      = '{pc: req_pc_q, instr: ic.ic_rsp_data};
    case (state_q)
      S_REQ: begin
        req_valid   = reset;
        fetch_stall = ~(reset & ic.ic_req_ready);
        if (reset && ic.ic_req_ready) begin
          req_pc_d = pc_in;
          drop_d   = flush;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ic.ic_rsp_valid) begin
          if (flush || drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else if (if_id_write) begin
            ld_valid = 1'b1;
            state_d  = S_REQ;
          end else begin
            hold_d  = ld_pkt;
            state_d = S_HOLD;
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (flush) begin
          state_d = S_REQ;
        end else if (if_id_write) begin
          ld_valid = 1'b1;
          ld_pkt   = hold_q;
          state_d  = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  assign ic.ic_req_valid = req_valid;
  assign ic.ic_req_addr  = pc_in;

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .write_en (if_id_write),
    .ld_valid (ld_valid),
    .ld_pkt   (ld_pkt),
    .id_valid (id_valid),
    .id_pc    (id_pc),
    .id_instr (id_instr)
  );

`ifdef IFETCH_IF_ID_PERF_EN
  logic [31:0] perf_stall_q;
  logic [15:0] perf_flush_q;

  // free-running wrap-around event counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (fetch_stall) perf_stall_q <= perf_stall_q + 32'd1;
      if (flush)       perf_flush_q <= perf_flush_q + 16'd1;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flush_count  = perf_flush_q;
`endif

endmodule

// File: tb/tb_ifetch_if_id.sv
// tb/tb_ifetch_if_id.sv - self-checking bench for ifetch_if_id
module tb_ifetch_if_id;
  import ifetch_if_id_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, if_id_write;
  logic [31:0] pc_in;
  logic        id_valid, fetch_stall;
  logic [31:0] id_pc, id_instr;
`ifdef IFETCH_IF_ID_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [15:0] perf_flush_count;
`endif

  ifetch_if_id_if ic();

  ifetch_if_id dut (
    .clk         (clk),
    .reset       (reset),
    .pc_in       (pc_in),
    .flush       (flush),
    .if_id_write (if_id_write),
    .ic          (ic),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_instr    (id_instr),
    .fetch_stall (fetch_stall)
`ifdef IFETCH_IF_ID_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_count  (perf_flush_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; pc_in = 32'h100; flush = 1'b0; if_id_write = 1'b1;
    ic.ic_req_ready = 1'b1; ic.ic_rsp_valid = 1'b0; ic.ic_rsp_data = '0;
    #1 reset = 1'b0;
    #1;
    total++;
    if ({id_valid, id_pc, id_instr} !== {1'b0, 32'h0, NOP_INSTR}) begin
      bad++; $display("FAIL reset_ifid got %h exp %h", {id_valid, id_pc, id_instr}, {1'b0, 32'h0, NOP_INSTR});
    end
    cyc(); cyc();
    total++;
    if ({ic.ic_req_valid, fetch_stall, id_valid} !== 3'b010) begin
      bad++; $display("FAIL reset_req got %b exp 010", {ic.ic_req_valid, fetch_stall, id_valid});
    end
  endtask

  task automatic test_hit();
    reset = 1'b1;
    #1;
    total++;
    if ({ic.ic_req_valid, ic.ic_req_addr, fetch_stall} !== {1'b1, 32'h100, 1'b0}) begin
      bad++; $display("FAIL hit_first_req got %h exp %h", {ic.ic_req_valid, ic.ic_req_addr, fetch_stall}, {1'b1, 32'h100, 1'b0});
    end
    cyc();
    ic.ic_rsp_valid = 1'b1; ic.ic_rsp_data = 32'hAAAA0001;
    #1;
    total++;
    if ({ic.ic_req_valid, fetch_stall, id_valid} !== 3'b010) begin
      bad++; $display("FAIL hit_wait got %b exp 010", {ic.ic_req_valid, fetch_stall, id_valid});
    end
    cyc();
    total++;
    if ({id_valid, id_pc, id_instr} !== {1'b1, 32'h100, 32'hAAAA0001}) begin
      bad++; $display("FAIL hit_ifid got %h exp %h", {id_valid, id_pc, id_instr}, {1'b1, 32'h100, 32'hAAAA0001});
    end
    ic.ic_rsp_valid = 1'b0; pc_in = 32'h104;
    #1;
    total++;
    if ({ic.ic_req_valid, ic.ic_req_addr, fetch_stall} !== {1'b1, 32'h104, 1'b0}) begin
      bad++; $display("FAIL hit_next_req got %h exp %h", {ic.ic_req_valid, ic.ic_req_addr, fetch_stall}, {1'b1, 32'h104, 1'b0});
    end
  endtask

  task automatic test_miss();
    cyc();
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({ic.ic_req_valid, fetch_stall} !== 2'b01) begin
        bad++; $display("FAIL miss_wait[%0d] got %b exp 01", i, {ic.ic_req_valid, fetch_stall});
      end
      cyc();
    end
    total++;
    if (id_valid !== 1'b0) begin
      bad++; $display("FAIL miss_bubble got %b exp 0", id_valid);
    end
    ic.ic_rsp_valid = 1'b1; ic.ic_rsp_data = 32'h12340004;
    cyc();
    total++;
    if ({id_valid, id_pc, id_instr} !== {1'b1, 32'h104, 32'h12340004}) begin
      bad++; $display("FAIL miss_ifid got %h exp %h", {id_valid, id_pc, id_instr}, {1'b1, 32'h104, 32'h12340004});
    end
    ic.ic_rsp_valid = 1'b0; pc_in = 32'h108;
    #1;
    total++;
    if ({ic.ic_req_valid, ic.ic_req_addr} !== {1'b1, 32'h108}) begin
      bad++; $display("FAIL miss_next_req got %h exp %h", {ic.ic_req_valid, ic.ic_req_addr}, {1'b1, 32'h108});
    end
  endtask

  task automatic test_decode_stall();
    cyc();
    ic.ic_rsp_valid = 1'b1; ic.ic_rsp_data = 32'hBBBB0002; if_id_write = 1'b0;
    cyc();
    ic.ic_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({ic.ic_req_valid, fetch_stall, id_valid} !== 3'b010) begin
        bad++; $display("FAIL stall_hold[%0d] got %b exp 010", i, {ic.ic_req_valid, fetch_stall, id_valid});
      end
      cyc();
    end
    if_id_write = 1'b1;
    cyc();
    total++;
    if ({id_valid, id_pc, id_instr} !== {1'b1, 32'h108, 32'hBBBB0002}) begin
      bad++; $display("FAIL stall_release got %h exp %h", {id_valid, id_pc, id_instr}, {1'b1, 32'h108, 32'hBBBB0002});
    end
    pc_in = 32'h10C;
    #1;
    total++;
    if ({ic.ic_req_valid, ic.ic_req_addr, fetch_stall} !== {1'b1, 32'h10C, 1'b0}) begin
      bad++; $display("FAIL stall_next_req got %h exp %h", {ic.ic_req_valid, ic.ic_req_addr, fetch_stall}, {1'b1, 32'h10C, 1'b0});
    end
  endtask

  task automatic test_flush_wait();
    pc_in = 32'h200;
    cyc();
    flush = 1'b1; pc_in = 32'h400;
    cyc();
    flush = 1'b0;
    cyc();
    ic.ic_rsp_valid = 1'b1; ic.ic_rsp_data = 32'hDEAD0003;
    cyc();
    ic.ic_rsp_valid = 1'b0;
    total++;
    if ({id_valid, id_instr} !== {1'b0, NOP_INSTR}) begin
      bad++; $display("FAIL flush_wait_discard got %h exp %h", {id_valid, id_instr}, {1'b0, NOP_INSTR});
    end
    #1;
    total++;
    if ({ic.ic_req_valid, ic.ic_req_addr} !== {1'b1, 32'h400}) begin
      bad++; $display("FAIL flush_wait_redirect got %h exp %h", {ic.ic_req_valid, ic.ic_req_addr}, {1'b1, 32'h400});
    end
  endtask

  task automatic test_flush_rsp_same();
    cyc();
    ic.ic_rsp_valid = 1'b1; ic.ic_rsp_data = 32'h11110005;
    cyc();
    ic.ic_rsp_valid = 1'b0; pc_in = 32'h404; if_id_write = 1'b0;
    cyc();
    ic.ic_rsp_valid = 1'b1; ic.ic_rsp_data = 32'h22220006; flush = 1'b1;
    cyc();
    flush = 1'b0; ic.ic_rsp_valid = 1'b0; ic.ic_req_ready = 1'b0;
    total++;
    if ({id_valid, id_pc, id_instr} !== {1'b0, 32'h0, NOP_INSTR}) begin
      bad++; $display("FAIL flush_rsp_ifid got %h exp %h", {id_valid, id_pc, id_instr}, {1'b0, 32'h0, NOP_INSTR});
    end
    #1;
    total++;
    if ({ic.ic_req_valid, ic.ic_req_addr, fetch_stall} !== {1'b1, 32'h404, 1'b1}) begin
      bad++; $display("FAIL flush_rsp_state got %h exp %h", {ic.ic_req_valid, ic.ic_req_addr, fetch_stall}, {1'b1, 32'h404, 1'b1});
    end
    if_id_write = 1'b1;
    cyc();
    total++;
    if ({id_valid, ic.ic_req_valid} !== 2'b01) begin
      bad++; $display("FAIL flush_rsp_hold_empty got %b exp 01", {id_valid, ic.ic_req_valid});
    end
  endtask

  task automatic test_async_reset();
    ic.ic_req_ready = 1'b1; pc_in = 32'h600; if_id_write = 1'b1;
    cyc();
    ic.ic_rsp_valid = 1'b1; ic.ic_rsp_data = 32'h33330007;
    cyc();
    ic.ic_rsp_valid = 1'b0; pc_in = 32'h604; if_id_write = 1'b0;
    cyc();
    total++;
    if ({id_valid, id_pc} !== {1'b1, 32'h600}) begin
      bad++; $display("FAIL areset_pre got %h exp %h", {id_valid, id_pc}, {1'b1, 32'h600});
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({id_valid, id_pc, id_instr, ic.ic_req_valid, fetch_stall} !== {1'b0, 32'h0, NOP_INSTR, 1'b0, 1'b1}) begin
      bad++; $display("FAIL areset_async got %h exp %h", {id_valid, id_pc, id_instr, ic.ic_req_valid, fetch_stall}, {1'b0, 32'h0, NOP_INSTR, 1'b0, 1'b1});
    end
    cyc(); cyc();
    reset = 1'b1; ic.ic_req_ready = 1'b0; ic.ic_rsp_valid = 1'b1; ic.ic_rsp_data = 32'h0BAD0BAD; if_id_write = 1'b1;
    cyc();
    total++;
    if ({id_valid, id_instr, ic.ic_req_valid, fetch_stall} !== {1'b0, NOP_INSTR, 1'b1, 1'b1}) begin
      bad++; $display("FAIL areset_stale got %h exp %h", {id_valid, id_instr, ic.ic_req_valid, fetch_stall}, {1'b0, NOP_INSTR, 1'b1, 1'b1});
    end
    ic.ic_rsp_valid = 1'b0;
  endtask

  typedef struct { logic [31:0] pc; bit killed; } out_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } pkt_t;

  task automatic test_random();
    out_t        oq[$];
    pkt_t        hq[$];
    out_t        e;
    pkt_t        p;
    bit          mv, new_ok, exp_req;
    logic [31:0] mpc, minstr, npc, ninstr;
    int          delay = 0;
    mv = 1'b0; mpc = '0; minstr = NOP_INSTR;
    flush = 1'b0; ic.ic_rsp_valid = 1'b0;
    reset = 1'b0;
    #1 reset = 1'b1;
    for (int n = 0; n < 600; n++) begin
      total++;
      if ({id_valid, id_pc, id_instr} !== {mv, mpc, minstr}) begin
        bad++; $display("FAIL rand_ifid[%0d] got %h exp %h", n, {id_valid, id_pc, id_instr}, {mv, mpc, minstr});
      end
      pc_in           = $urandom & 32'hFFFF_FFFC;
      ic.ic_req_ready = ($urandom_range(0, 2) != 0);
      flush           = ($urandom_range(0, 9) == 0);
      if_id_write     = ($urandom_range(0, 3) != 0);
      ic.ic_rsp_data  = $urandom;
      if (oq.size() != 0) begin
        ic.ic_rsp_valid = (delay == 0);
        if (delay > 0) delay--;
      end else begin
        ic.ic_rsp_valid = ($urandom_range(0, 19) == 0);
      end
      exp_req = (oq.size() == 0) && (hq.size() == 0);
      #1;
      total++;
      if ({ic.ic_req_valid, fetch_stall} !== {exp_req, !(exp_req && ic.ic_req_ready)}) begin
        bad++; $display("FAIL rand_req[%0d] got %b exp %b", n, {ic.ic_req_valid, fetch_stall}, {exp_req, !(exp_req && ic.ic_req_ready)});
      end
      if (exp_req) begin
        total++;
        if (ic.ic_req_addr !== pc_in) begin
          bad++; $display("FAIL rand_addr[%0d] got %h exp %h", n, ic.ic_req_addr, pc_in);
        end
      end
      new_ok = 1'b0; npc = '0; ninstr = NOP_INSTR;
      if (exp_req) begin
        if (ic.ic_req_ready) begin
          oq.push_back('{pc: pc_in, killed: flush});
          delay = $urandom_range(0, 3);
        end
      end else if (oq.size() != 0) begin
        if (ic.ic_rsp_valid) begin
          e = oq.pop_front();
          if (!e.killed && !flush) begin
            if (if_id_write) begin
              new_ok = 1'b1; npc = e.pc; ninstr = ic.ic_rsp_data;
            end else begin
              hq.push_back('{pc: e.pc, instr: ic.ic_rsp_data});
            end
          end
        end else if (flush) begin
          oq[0].killed = 1'b1;
        end
      end else begin
        if (flush) hq.delete();
        else if (if_id_write) begin
          p = hq.pop_front();
          new_ok = 1'b1; npc = p.pc; ninstr = p.instr;
        end
      end
      if (flush || (if_id_write && !new_ok)) begin
        mv = 1'b0; mpc = '0; minstr = NOP_INSTR;
      end else if (if_id_write) begin
        mv = 1'b1; mpc = npc; minstr = ninstr;
      end
      cyc();
    end
    total++;
    if ({id_valid, id_pc, id_instr} !== {mv, mpc, minstr}) begin
      bad++; $display("FAIL rand_final got %h exp %h", {id_valid, id_pc, id_instr}, {mv, mpc, minstr});
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_miss();
    test_decode_stall();
    test_flush_wait();
    test_flush_rsp_same();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
